// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointer control for a FIFO whose full/empty flags come from an external compare stage.
// Gates memory strobes, tracks fill level, almost flags and sticky overflow/underflow errors.
module fifo_ptr_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write_ena,
   input  logic                  read_ena,
   input  logic                  full,
   input  logic                  empty,
   input  logic                  err_clr,
   output logic [ADDR_WIDTH:0]   write_addr,
   output logic [ADDR_WIDTH:0]   read_addr,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [PW-1:0] ONE       = PW'(1);
   localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
   localparam logic [PW-1:0] AE_THRESH = PW'(AE_MARGIN);

   logic          wr_acc;
   logic          rd_acc;
   logic [PW-1:0] next_write_addr;
   logic [PW-1:0] next_read_addr;
   logic [PW-1:0] next_level;

   always_comb begin
      wr_acc          = write_ena & ~full;
      rd_acc          = read_ena & ~empty;
      next_write_addr = write_addr;
      next_read_addr  = read_addr;
      next_level      = level;
      // Pointers wrap through the extra MSB so the compare stage can tell full from empty
      if (wr_acc) begin
         next_write_addr = write_addr + ONE;
      end
      if (rd_acc) begin
         next_read_addr = read_addr + ONE;
      end
      if (wr_acc && !rd_acc) begin
         next_level = level + ONE;
      end else if (rd_acc && !wr_acc) begin
         next_level = level - ONE;
      end
   end

   assign mem_we    = wr_acc;
   assign mem_re    = rd_acc;
   assign mem_waddr = write_addr[ADDR_WIDTH-1:0];
   assign mem_raddr = read_addr[ADDR_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_addr   <= '0;
         read_addr    <= '0;
         level        <= '0;
         rd_valid     <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         write_addr   <= next_write_addr;
         read_addr    <= next_read_addr;
         level        <= next_level;
         rd_valid     <= rd_acc;
         // Almost flags come from the next level so they line up with the registered level
         almost_full  <= (next_level >= AF_THRESH);
         almost_empty <= (next_level <= AE_THRESH);
         // A fresh error outranks a simultaneous clear
         overflow     <= (overflow & ~err_clr) | (write_ena & full);
         underflow    <= (underflow & ~err_clr) | (read_ena & empty);
      end
   end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Pointer-control stage that sits directly upstream of the FIFO full/empty compare logic. It owns the write and read pointers, each ADDR_WIDTH+1 bits wide with a wrap bit in the MSB. It consumes the compare stage's full/empty to gate accesses and drives the memory write/read strobes. It also keeps a registered fill level, almost-full/almost-empty flags and sticky overflow/underflow error flags.

Parameters:
ADDR_WIDTH, 4, memory address bits; DEPTH = 2**ADDR_WIDTH entries
AF_MARGIN, 1, almost_full asserts when level >= DEPTH - AF_MARGIN
AE_MARGIN, 1, almost_empty asserts when level <= AE_MARGIN

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
write_ena  in  1  write request
read_ena  in  1  read request
full  in  1  from compare stage (combinational on write_addr/read_addr)
empty  in  1  from compare stage (combinational on write_addr/read_addr)
err_clr  in  1  clears sticky error flags
write_addr  out  ADDR_WIDTH+1  write pointer (MSB = wrap bit), registered
read_addr  out  ADDR_WIDTH+1  read pointer (MSB = wrap bit), registered
mem_we  out  1  memory write strobe, combinational
mem_waddr  out  ADDR_WIDTH  write_addr[ADDR_WIDTH-1:0]
mem_re  out  1  memory read strobe, combinational
mem_raddr  out  ADDR_WIDTH  read_addr[ADDR_WIDTH-1:0]
rd_valid  out  1  read data valid, one cycle after mem_re
level  out  ADDR_WIDTH+1  entries held, 0..DEPTH, registered
almost_full  out  1  registered
almost_empty  out  1  registered
overflow  out  1  sticky; set by a write attempted while full
underflow  out  1  sticky; set by a read attempted while empty

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - write_addr=0, read_addr=0, level=0.
  - rd_valid=0, overflow=0, underflow=0, almost_full=0, almost_empty=1.
  - Reset mid-operation discards all contents; there is no drain.
- Accept rules:
  - wr_acc = write_ena & ~full; rd_acc = read_ena & ~empty.
  - mem_we = wr_acc; mem_re = rd_acc. Both are combinational in the same cycle.
- Pointers:
  - On wr_acc, write_addr <= write_addr+1, modulo 2**(ADDR_WIDTH+1), so the MSB toggles on wrap. Same rule for read_addr on rd_acc.
  - Rejected requests leave the pointers unchanged.
- Simultaneous write and read:
  - full and empty are evaluated on current pointers.
  - When full, the write is rejected and the read is accepted; level drops by 1.
  - When empty, the read is rejected and the write is accepted; level rises by 1.
  - Neither flag set: both are accepted, both pointers advance, level is unchanged.
- Level update: level <= level + wr_acc - rd_acc. Invariant: level == write_addr - read_addr, modulo 2**(ADDR_WIDTH+1).
- Almost flags:
  - Computed from the next level and registered, so they align with level.
  - almost_full = (next_level >= DEPTH-AF_MARGIN); almost_empty = (next_level <= AE_MARGIN).
- rd_valid <= rd_acc, giving 1-cycle read latency to match a synchronous-read memory.
- Errors:
  - overflow <= 1 when write_ena & full; underflow <= 1 when read_ena & empty.
  - err_clr clears both flags. If err_clr and a new error occur in the same cycle, the set wins.
  - Errors do not block operation.
- Pointers must never advance past full or below empty for any request sequence.

Test Plan:
(All with ADDR_WIDTH=2, DEPTH=4, AF_MARGIN=1, AE_MARGIN=1, compare stage connected.)
- Reset, then 4 writes with no reads:
  - write_addr steps 0→1→2→3→4 (3'b100) and level reaches 4; full=1.
  - almost_full=1 from level 3.
  - A 5th write gives mem_we=0, write_addr stays 4, overflow=1.
- From full, 4 reads:
  - read_addr steps 0→4; mem_re=1 each cycle; rd_valid follows mem_re by 1 cycle.
  - Ends with empty=1, level=0; a 5th read sets underflow=1.
- Wrap: 6 writes and 6 reads interleaved with level ≤2:
  - write_addr passes 7→0 with the MSB toggling.
  - empty=1 exactly when the pointers are equal; level matches the pointer difference every cycle.
- Simultaneous write+read in three states:
  - At level=2, both pointers advance and level stays 2.
  - At full, only read_addr advances and level goes 4→3.
  - At empty, only write_addr advances and level goes 0→1.
- Errors and reset:
  - err_clr clears overflow; err_clr together with a write-while-full keeps overflow=1.
  - rst_n=0 at level 3 returns all outputs to reset values on the next edge.
